// File: rtl/result_packer_pkg.sv
// Shared constants and types for the activation write-back packer.
// Precision codes, SRAM word/address widths, FSM states and the slot helper.
package result_packer_pkg;

  localparam int ACT_WORD_W = 128;
  localparam int ACT_ADDR_W = 12;

  localparam logic [1:0] PREC_2B  = 2'd0;
  localparam logic [1:0] PREC_4B  = 2'd1;
  localparam logic [1:0] PREC_8B  = 2'd2;
  localparam logic [1:0] PREC_16B = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Index of the last beat slot in a word (beats per word minus one).
  function automatic logic [2:0] last_slot(input logic [1:0] prec);
    case (prec)
      PREC_2B: return 3'd7;
      PREC_4B: return 3'd3;
      PREC_8B: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/result_packer_sync_fifo.sv
// Registered show-ahead FIFO holding packed activation words.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/result_packer.sv
// Packs 8-lane quantized activation beats into dense 128-bit words at the
// next layer's precision and writes them to the activation SRAM in sequence.
module result_packer
  import result_packer_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int SLOT_W     = 16,
  parameter int WORD_W     = ACT_WORD_W,
  parameter int ADDR_W     = ACT_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      layer_start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [15:0]               num_beats,
  input  logic [1:0]                fmap_precision,
  input  logic                      in_vld,
  input  logic [LANES*SLOT_W-1:0]   in_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [WORD_W-1:0]         wr_data,
  input  logic                      wr_rdy,
  output logic                      busy,
  output logic                      layer_done,
  output logic                      ovf_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [WORD_W-1:0] pack_chunk(input logic [LANES*SLOT_W-1:0] d,
                                                   input logic [1:0] prec);
    logic [WORD_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      case (prec)
        PREC_2B: c[i*2 +: 2]   = d[i*SLOT_W +: 2];
        PREC_4B: c[i*4 +: 4]   = d[i*SLOT_W +: 4];
        PREC_8B: c[i*8 +: 8]   = d[i*SLOT_W +: 8];
        default: c[i*16 +: 16] = d[i*SLOT_W +: 16];
      endcase
    end
    return c;
  endfunction

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         num_beats_q;
  logic [1:0]          prec_q;
  logic [15:0]         beat_cnt;
  logic [2:0]          slot_cnt;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [WORD_W-1:0]   asm_q;
  logic [WORD_W-1:0]   asm_next;
  logic [6:0]          shamt;
  logic                accept;
  logic                last_beat;
  logic                word_done;
  logic                push_now;
  logic [WORD_W-1:0]   word_p1;
  logic                push_vld_p1;
  logic [WORD_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                pop;
  logic                drop;

  // Stage p0: place the incoming chunk at its slot in the assembly word
  assign accept    = (state == S_RUN) && in_vld;
  assign last_beat = (beat_cnt == num_beats_q - 16'd1);
  assign word_done = (slot_cnt == last_slot(prec_q));
  assign push_now  = accept && (word_done || last_beat);
  assign shamt     = {4'd0, slot_cnt} << (3'd4 + {1'b0, prec_q});
  assign asm_next  = asm_q | (pack_chunk(in_data, prec_q) << shamt);

  always_ff @(posedge clk) begin
    if (state == S_IDLE && layer_start) begin
      asm_q <= '0;
    end else if (accept) begin
      asm_q <= push_now ? '0 : asm_next;
    end
    if (push_now) word_p1 <= asm_next;
  end

  // Stage p1: completed word enters the FIFO; the write port drains it
  assign pop     = !fifo_empty && wr_rdy;
  assign drop    = push_vld_p1 && fifo_full && !pop;
  assign wr_en   = !fifo_empty;
  assign wr_data = fifo_empty ? '0 : fifo_head;
  assign wr_addr = base_q + wr_cnt;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_vld_p1),
    .din   (word_p1),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      num_beats_q <= '0;
      prec_q      <= '0;
      beat_cnt    <= '0;
      slot_cnt    <= '0;
      wr_cnt      <= '0;
      push_vld_p1 <= 1'b0;
      busy        <= 1'b0;
      layer_done  <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      layer_done  <= 1'b0;
      push_vld_p1 <= push_now;
      if (pop)  wr_cnt  <= wr_cnt + ADDR_W'(1);
      if (drop) ovf_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (layer_start) begin
            base_q      <= base_addr;
            num_beats_q <= num_beats;
            prec_q      <= fmap_precision;
            beat_cnt    <= '0;
            slot_cnt    <= '0;
            wr_cnt      <= '0;
            ovf_err     <= 1'b0;
            busy        <= 1'b1;
            if (num_beats == 16'd0) begin
              state      <= S_DONE;
              layer_done <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 16'd1;
            slot_cnt <= word_done ? 3'd0 : slot_cnt + 3'd1;
            if (last_beat) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish as the final word leaves, so layer_done follows the last write directly
          if (!push_vld_p1 && (fifo_empty || (fifo_cnt == CNT_W'(1) && pop))) begin
            state      <= S_DONE;
            layer_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed layers plus randomized layers
// compared against a bit-stream packing model.
module tb_result_packer;
  import result_packer_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         layer_start;
  logic [11:0]  base_addr;
  logic [15:0]  num_beats;
  logic [1:0]   fmap_precision;
  logic         in_vld;
  logic [127:0] in_data;
  logic         wr_en;
  logic [11:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         busy;
  logic         layer_done;
  logic         ovf_err;

  result_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .layer_start    (layer_start),
    .base_addr      (base_addr),
    .num_beats      (num_beats),
    .fmap_precision (fmap_precision),
    .in_vld         (in_vld),
    .in_data        (in_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_rdy         (wr_rdy),
    .busy           (busy),
    .layer_done     (layer_done),
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          wr_q[$];
  logic [127:0] beat_q[$];
  logic [127:0] exp_words[$];
  int           cyc = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           last_wr_cyc = 0;
  int           errors = 0;
  int           checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en && wr_rdy) begin
      wr_q.push_back('{wr_addr, wr_data});
      last_wr_cyc = cyc;
    end
    if (layer_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Activation n occupies bits [n*P +: P] of a continuous little-endian stream cut into 128-bit words
  task automatic build_expected(input logic [1:0] prec);
    int p;
    int n;
    int bitpos;
    logic [31:0] v;
    p = 2 << prec;
    n = 0;
    exp_words.delete();
    foreach (beat_q[b]) begin
      for (int l = 0; l < 8; l++) begin
        v = {16'd0, beat_q[b][l*16 +: 16]} & ((32'd1 << p) - 32'd1);
        bitpos = n * p;
        while (exp_words.size() <= bitpos / 128) exp_words.push_back(128'd0);
        exp_words[bitpos / 128] = exp_words[bitpos / 128] | (128'(v) << (bitpos % 128));
        n++;
      end
    end
  endtask

  task automatic start_layer(input logic [11:0] base, input logic [15:0] nb, input logic [1:0] prec);
    beat_q.delete();
    wr_q.delete();
    layer_start    = 1'b1;
    base_addr      = base;
    num_beats      = nb;
    fmap_precision = prec;
    tick();
    layer_start    = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d);
    in_vld  = 1'b1;
    in_data = d;
    beat_q.push_back(d);
    tick();
    in_vld  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 128'(done_cnt - start), 128'd1);
    tick();
    tick();
  endtask

  task automatic check_writes(input string tag, input logic [11:0] base);
    logic [11:0] a;
    check({tag, "_nwr"}, 128'(wr_q.size()), 128'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < wr_q.size(); i++) begin
      a = base + 12'(i);
      check($sformatf("%s_addr%0d", tag, i), 128'(wr_q[i].addr), 128'(a));
      check($sformatf("%s_data%0d", tag, i), wr_q[i].data, exp_words[i]);
    end
  endtask

  function automatic logic [127:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] b;
    logic [127:0] d0;
    int nb;
    logic [1:0]  prec;
    logic [11:0] base;

    rst_n = 1'b0;
    layer_start = 1'b0;
    base_addr = '0;
    num_beats = '0;
    fmap_precision = '0;
    in_vld = 1'b0;
    in_data = '0;
    wr_rdy = 1'b1;
    tick();
    tick();
    check("rst_wr_en", 128'(wr_en), 128'd0);
    check("rst_wr_addr", 128'(wr_addr), 128'd0);
    check("rst_wr_data", wr_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_layer_done", 128'(layer_done), 128'd0);
    check("rst_ovf_err", 128'(ovf_err), 128'd0);
    rst_n = 1'b1;
    tick();

    // 8b layer, lanes = i+1, two full words
    start_layer(12'h010, 16'd4, PREC_8B);
    check("t1_busy", 128'(busy), 128'd1);
    for (int l = 0; l < 8; l++) b[l*16 +: 16] = 16'(l + 1);
    for (int i = 0; i < 4; i++) send_beat(b);
    wait_done("t1", 50);
    build_expected(PREC_8B);
    check_writes("t1", 12'h010);
    d0 = (wr_q.size() > 0) ? wr_q[0].data : 'x;
    check("t1_data_const", d0, 128'h0807060504030201_0807060504030201);
    check("t1_done_lat", 128'(done_cyc - last_wr_cyc), 128'd1);
    check("t1_busy_end", 128'(busy), 128'd0);

    // 2b layer, partial final word
    start_layer(12'h020, 16'd3, PREC_2B);
    for (int l = 0; l < 8; l++) b[l*16 +: 16] = 16'd3;
    for (int i = 0; i < 3; i++) send_beat(b);
    wait_done("t2", 50);
    build_expected(PREC_2B);
    check_writes("t2", 12'h020);
    d0 = (wr_q.size() > 0) ? wr_q[0].data : 'x;
    check("t2_data_const", d0, 128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF);

    // 16b layer with SRAM stalled: FIFO overflows and drops the last two words
    wr_rdy = 1'b0;
    start_layer(12'h300, 16'd6, PREC_16B);
    for (int i = 0; i < 6; i++) send_beat(rand_beat());
    build_expected(PREC_16B);
    tick();
    check("t3_stall_wr_en", 128'(wr_en), 128'd1);
    check("t3_stall_addr", 128'(wr_addr), 128'h300);
    check("t3_stall_data_a", wr_data, exp_words[0]);
    tick();
    tick();
    check("t3_stall_data_b", wr_data, exp_words[0]);
    check("t3_ovf_set", 128'(ovf_err), 128'd1);
    tick();
    wr_rdy = 1'b1;
    wait_done("t3", 50);
    while (exp_words.size() > 4) void'(exp_words.pop_back());
    check_writes("t3", 12'h300);
    check("t3_ovf_sticky", 128'(ovf_err), 128'd1);

    // 4b layer whose second word wraps the address space
    start_layer(12'hFFF, 16'd8, PREC_4B);
    check("t4_ovf_cleared", 128'(ovf_err), 128'd0);
    for (int i = 0; i < 8; i++) send_beat(rand_beat());
    wait_done("t4", 50);
    build_expected(PREC_4B);
    check_writes("t4", 12'hFFF);
    check("t4_wrap_addr", (wr_q.size() > 1) ? 128'(wr_q[1].addr) : 'x, 128'h000);

    // Empty layer
    start_layer(12'h055, 16'd0, PREC_8B);
    check("t5_done_now", 128'(layer_done), 128'd1);
    tick();
    check("t5_done_pulse", 128'(layer_done), 128'd0);
    tick();
    check("t5_no_writes", 128'(wr_q.size()), 128'd0);
    check("t5_idle", 128'(busy), 128'd0);

    // Reset during RUN with two words queued
    wr_rdy = 1'b0;
    start_layer(12'h200, 16'd4, PREC_16B);
    send_beat(rand_beat());
    send_beat(rand_beat());
    tick();
    tick();
    check("t6_queued", 128'(wr_en), 128'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", 128'(wr_en), 128'd0);
    check("t6_rst_busy", 128'(busy), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wr_rdy = 1'b1;
    tick();
    tick();
    check("t6_after_wr_en", 128'(wr_en), 128'd0);
    check("t6_after_busy", 128'(busy), 128'd0);
    check("t6_after_nwr", 128'(wr_q.size()), 128'd0);
    start_layer(12'h100, 16'd2, PREC_8B);
    send_beat(rand_beat());
    send_beat(rand_beat());
    wait_done("t6", 50);
    build_expected(PREC_8B);
    check_writes("t6", 12'h100);

    // Randomized layers with input gaps and a free-running SRAM
    for (int it = 0; it < 8; it++) begin
      prec = 2'($urandom_range(0, 3));
      nb   = $urandom_range(1, 12);
      base = 12'($urandom);
      start_layer(base, 16'(nb), prec);
      for (int s = 0; s < nb; ) begin
        if ($urandom_range(0, 2) == 0) begin
          tick();
        end else begin
          send_beat(rand_beat());
          s++;
        end
      end
      wait_done($sformatf("r%0d", it), 60);
      build_expected(prec);
      check_writes($sformatf("r%0d", it), base);
      check($sformatf("r%0d_ovf", it), 128'(ovf_err), 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
